memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Parametrised memory pipeline stage placed between execute and writeback. It drives a request/acknowledge data bus with byte strobes, so bus latency is variable, and it requests a pipeline stall while a transaction is in flight. It aligns and sign- or zero-extends load data, and raises misaligned and access-fault exceptions, including a bus timeout. Supports XLEN 32 or 64.

## Interface
- XLEN, 32: data/address width; 32 or 64.
- TIMEOUT, 16: maximum WAIT cycles without bus_ack before an access fault; 0 disables the timeout.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- valid_in, exception_in  in  1  instruction valid; upstream exception
- ecause_in  in  4  upstream exception cause
- rd_address_in  in  5  destination register
- alu_data_in  in  XLEN  non-memory result
- alu_addition_in  in  XLEN  effective address
- rs2_data_in  in  XLEN  store data
- load_in, store_in, load_signed_in  in  1  access type; signed load
- load_store_size_in  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64)
- stall, invalidate  in  1  from hazard unit
- stall_request  out  1  to hazard unit; holds execute and earlier stages
- bus_req, bus_we  out  1  request; write enable
- bus_address  out  XLEN  address aligned down to XLEN/8 bytes
- bus_wdata  out  XLEN  lane-shifted store data
- bus_strobe  out  XLEN/8  byte enables
- bus_ack, bus_error  in  1  completion; error completion
- bus_rdata  in  XLEN  read data
- valid_out, exception_out  out  1  to writeback
- ecause_out  out  4  exception cause
- rd_address_out  out  5  destination register
- result_out  out  XLEN  formatted load data, or alu_data_in

## Operation
- go = valid_in && !exception_in && !invalidate && (load_in || store_in).
- Alignment check:
  - Byte: always aligned.
  - Half: addr[0] must be 0.
  - Word: addr[1:0] must be 0.
  - Double: addr[2:0] must be 0 when XLEN=64; always misaligned when XLEN=32.
- States:
  - IDLE:
    - go and aligned: latch the bus fields, go to WAIT, assert stall_request.
    - go and misaligned: no bus activity; the writeback register captures exception_out=1, ecause 4 (load) or 6 (store).
    - Otherwise: the writeback register captures pass-through.
  - WAIT:
    - bus_req=1; all bus outputs held stable.
    - Completion is bus_ack, bus_error, or timeout. On completion with stall=0, capture the result and return to IDLE. On completion with stall=1, capture into a hold register and go to DONE.
  - DONE: stall_request=0; when stall=0, the writeback register loads the hold register and the state returns to IDLE.
- stall_request = (IDLE && go && aligned) || (WAIT && !completion).
- Error precedence: bus_error beats bus_ack in the same cycle. bus_error or timeout gives ecause 5 (load) or 7 (store) with exception_out=1.
- Timeout:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - Timeout fires in the cycle the counter equals TIMEOUT-1 with no ack or error.
- Store formatting:
  - offset = addr[log2(XLEN/8)-1:0].
  - bus_wdata = rs2 << 8·offset.
  - bus_strobe = ((1<<2^size)-1) << offset.
- Load formatting: shift bus_rdata right by 8·offset, truncate to the access size, then sign-extend if load_signed_in, else zero-extend.
- Invalidate:
  - Any state: valid_out is cleared at the edge.
  - In WAIT: the transaction is never aborted. An abort flag is set, the state stays WAIT until completion, the result and exception are discarded, and valid_out remains 0.
- Writeback register: updates when !stall && !stall_request; otherwise holds. valid_out = (held or new valid) && !invalidate.
- bus_ack and bus_error outside WAIT are ignored.

## Timing
- All outputs except stall_request are registered.
- Reset values: state IDLE; bus_req, bus_we 0; bus_address, bus_wdata, bus_strobe 0; valid_out, exception_out 0; ecause_out, rd_address_out, result_out 0; timeout counter 0; abort flag 0.
- Latency:
  - Non-memory or faulting instruction: 1 cycle.
  - Memory access: 1 IDLE cycle plus N WAIT cycles. With ack in the first WAIT cycle, the access takes 2 cycles total.
- Reset mid-WAIT drops bus_req immediately (asynchronous reset). The bus agent must tolerate a dropped request.
- Back-to-back accesses: IDLE may accept the next op in the cycle after completion. There is no dead cycle beyond the IDLE issue cycle.

## Test plan
- Word load at 0x1000, ack on the 3rd WAIT cycle, rdata 0xDEADBEEF: stall_request high for 3 cycles, then result_out=0xDEADBEEF, valid_out=1.
- Signed byte load at 0x1003, rdata 0x80123456: bus_address 0x1000, result_out 0xFFFFFF80. Unsigned: 0x00000080.
- Half store at 0x2002, rs2 0x0000ABCD: bus_we=1, bus_strobe=1100, bus_wdata=0xABCD0000.
- Word load at 0x1002: no bus_req, exception_out=1, ecause_out=4, one cycle. XLEN=32 with size 11: same, ecause 4 or 6.
- TIMEOUT=4, no ack: bus_req high exactly 4 cycles, then exception_out=1, ecause 5. bus_error with bus_ack on a store: ecause 7.
- Store in WAIT with invalidate pulsed, ack 2 cycles later: bus_req held until ack, valid_out=0. Ack with stall=1: state DONE, result appears on the first cycle stall=0.

Source files
------------

// File: rtl/memory_access_stage.sv
// Memory pipeline stage: drives a req/ack data bus with byte strobes, stalls the pipeline while a
// transaction is in flight, formats load data and reports alignment, bus-error and timeout faults.
module memory_access_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              exception_in,
  input  logic [3:0]        ecause_in,
  input  logic [4:0]        rd_address_in,
  input  logic [XLEN-1:0]   alu_data_in,
  input  logic [XLEN-1:0]   alu_addition_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic              load_in,
  input  logic              store_in,
  input  logic              load_signed_in,
  input  logic [1:0]        load_store_size_in,
  input  logic              stall,
  input  logic              invalidate,
  output logic              stall_request,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_address,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_strobe,
  input  logic              bus_ack,
  input  logic              bus_error,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              valid_out,
  output logic              exception_out,
  output logic [3:0]        ecause_out,
  output logic [4:0]        rd_address_out,
  output logic [XLEN-1:0]   result_out
);
  localparam int unsigned StrbW = XLEN / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
  state_e state_q, state_d;

  logic            is_load_q, is_signed_q, abort_q;
  logic [1:0]      size_q;
  logic [OffW-1:0] offset_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q;
  logic [CntW-1:0] count_q;

  // Result of an access that completed while the hazard unit held the pipeline
  logic            hold_valid_q, hold_exc_q;
  logic [3:0]      hold_ecause_q;
  logic [4:0]      hold_rd_q;
  logic [XLEN-1:0] hold_result_q;

  logic             go, misaligned, timeout, completion, fault, sign, issue, wb_en;
  logic [StrbW-1:0] strobe;
  logic [XLEN-1:0]  shifted, mask, load_data, done_result;
  logic [3:0]       done_ecause;
  logic             done_valid;
  logic             wb_valid_d, wb_exc_d;
  logic [3:0]       wb_ecause_d;
  logic [4:0]       wb_rd_d;
  logic [XLEN-1:0]  wb_result_d;

  assign go = valid_in && !exception_in && !invalidate && (load_in || store_in);

  always_comb begin
    case (load_store_size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_addition_in[0];
      2'b10:   misaligned = |alu_addition_in[1:0];
      default: misaligned = (XLEN == 64) ? |alu_addition_in[2:0] : 1'b1;
    endcase
  end

  assign issue  = (state_q == StIdle) && go && !misaligned;
  assign strobe = StrbW'((32'd1 << (32'd1 << load_store_size_in)) - 32'd1)
                  << alu_addition_in[OffW-1:0];

  assign timeout    = (TIMEOUT != 0) && (count_q == CntW'(TIMEOUT - 1)) && !bus_ack && !bus_error;
  assign completion = (state_q == StWait) && (bus_ack || bus_error || timeout);
  assign fault      = bus_error || timeout;

  // A shift by the full width yields zero, so the mask is all ones for XLEN-sized loads
  assign shifted   = bus_rdata >> {offset_q, 3'b000};
  assign mask      = (XLEN'(1) << (32'd8 << size_q)) - XLEN'(1);
  assign sign      = is_signed_q && |(shifted & mask & ~(mask >> 1));
  assign load_data = (shifted & mask) | (sign ? ~mask : '0);

  assign done_valid  = !abort_q && !invalidate;
  assign done_ecause = fault ? (is_load_q ? 4'd5 : 4'd7) : 4'd0;
  assign done_result = fault ? '0 : (is_load_q ? load_data : alu_q);

  always_comb begin
    state_d       = state_q;
    stall_request = 1'b0;
    unique case (state_q)
      StIdle: if (issue) begin
        state_d       = StWait;
        stall_request = 1'b1;
      end
      StWait: begin
        stall_request = !completion;
        if (completion) state_d = stall ? StDone : StIdle;
      end
      StDone:  if (!stall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign wb_en = !stall && !stall_request;

  always_comb begin
    wb_valid_d  = valid_in;
    wb_exc_d    = exception_in;
    wb_ecause_d = ecause_in;
    wb_rd_d     = rd_address_in;
    wb_result_d = alu_data_in;
    unique case (state_q)
      StIdle: if (go && misaligned) begin
        wb_exc_d    = 1'b1;
        wb_ecause_d = load_in ? 4'd4 : 4'd6;
      end
      StWait: begin
        wb_valid_d  = done_valid;
        wb_exc_d    = fault;
        wb_ecause_d = done_ecause;
        wb_rd_d     = rd_q;
        wb_result_d = done_result;
      end
      StDone: begin
        wb_valid_d  = hold_valid_q;
        wb_exc_d    = hold_exc_q;
        wb_ecause_d = hold_ecause_q;
        wb_rd_d     = hold_rd_q;
        wb_result_d = hold_result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      bus_req        <= 1'b0;
      bus_we         <= 1'b0;
      bus_address    <= '0;
      bus_wdata      <= '0;
      bus_strobe     <= '0;
      valid_out      <= 1'b0;
      exception_out  <= 1'b0;
      ecause_out     <= '0;
      rd_address_out <= '0;
      result_out     <= '0;
      is_load_q      <= 1'b0;
      is_signed_q    <= 1'b0;
      abort_q        <= 1'b0;
      size_q         <= '0;
      offset_q       <= '0;
      rd_q           <= '0;
      alu_q          <= '0;
      count_q        <= '0;
      hold_valid_q   <= 1'b0;
      hold_exc_q     <= 1'b0;
      hold_ecause_q  <= '0;
      hold_rd_q      <= '0;
      hold_result_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_out <= (wb_en ? wb_valid_d : valid_out) && !invalidate;
      if (wb_en) begin
        exception_out  <= wb_exc_d;
        ecause_out     <= wb_ecause_d;
        rd_address_out <= wb_rd_d;
        result_out     <= wb_result_d;
      end
      if (issue) begin
        bus_req     <= 1'b1;
        bus_we      <= store_in && !load_in;
        bus_address <= {alu_addition_in[XLEN-1:OffW], OffW'(0)};
        bus_wdata   <= rs2_data_in << {alu_addition_in[OffW-1:0], 3'b000};
        bus_strobe  <= strobe;
        is_load_q   <= load_in;
        is_signed_q <= load_signed_in;
        size_q      <= load_store_size_in;
        offset_q    <= alu_addition_in[OffW-1:0];
        rd_q        <= rd_address_in;
        alu_q       <= alu_data_in;
        count_q     <= '0;
        abort_q     <= 1'b0;
      end
      if (state_q == StWait) begin
        count_q <= count_q + 1'b1;
        if (invalidate) abort_q <= 1'b1;
        if (completion) begin
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
          abort_q <= 1'b0;
        end
        if (completion && stall) begin
          hold_valid_q  <= done_valid;
          hold_exc_q    <= fault;
          hold_ecause_q <= done_ecause;
          hold_rd_q     <= rd_q;
          hold_result_q <= done_result;
        end
      end
      if (state_q == StDone && invalidate) hold_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage (XLEN=32, TIMEOUT=4): directed vectors push expected
// bus requests and writeback results; a monitor pops and compares as the DUT presents them.
module tb_memory_access_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0, exception_in = 1'b0;
  logic [3:0]  ecause_in = '0;
  logic [4:0]  rd_address_in = '0;
  logic [31:0] alu_data_in = '0, alu_addition_in = '0, rs2_data_in = '0;
  logic        load_in = 1'b0, store_in = 1'b0, load_signed_in = 1'b0;
  logic [1:0]  load_store_size_in = '0;
  logic        stall = 1'b0, invalidate = 1'b0;
  logic        stall_request, bus_req, bus_we;
  logic [31:0] bus_address, bus_wdata;
  logic [3:0]  bus_strobe;
  logic        bus_ack = 1'b0, bus_error = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        valid_out, exception_out;
  logic [3:0]  ecause_out;
  logic [4:0]  rd_address_out;
  logic [31:0] result_out;

  always #5 clk = ~clk;

  memory_access_stage #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .exception_in(exception_in),
    .ecause_in(ecause_in), .rd_address_in(rd_address_in), .alu_data_in(alu_data_in),
    .alu_addition_in(alu_addition_in), .rs2_data_in(rs2_data_in), .load_in(load_in),
    .store_in(store_in), .load_signed_in(load_signed_in),
    .load_store_size_in(load_store_size_in), .stall(stall), .invalidate(invalidate),
    .stall_request(stall_request), .bus_req(bus_req), .bus_we(bus_we),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_strobe(bus_strobe),
    .bus_ack(bus_ack), .bus_error(bus_error), .bus_rdata(bus_rdata), .valid_out(valid_out),
    .exception_out(exception_out), .ecause_out(ecause_out), .rd_address_out(rd_address_out),
    .result_out(result_out)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;
  typedef struct {
    logic        exc;
    logic [3:0]  ec;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        chk_res;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  bus_t be;
  wb_t  we_exp;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] addr, wdata, input logic [3:0] strb);
    bus_q.push_back('{we: we, addr: addr, wdata: wdata, strb: strb});
  endtask

  task automatic exp_wb(input logic exc, input logic [3:0] ec, input logic [4:0] rd,
                        input logic [31:0] res, input logic chk_res);
    wb_q.push_back('{exc: exc, ec: ec, rd: rd, res: res, chk_res: chk_res});
  endtask

  // Bus agent: acknowledges in WAIT cycle number ack_at (0 = never)
  int          ack_at = 0;
  int          bus_cyc = 0;
  logic        ack_err = 1'b0;
  logic [31:0] rdata_val = '0;
  always @(posedge clk) begin
    #1;
    if (bus_req) bus_cyc++;
    else bus_cyc = 0;
    bus_ack   = bus_req && (ack_at != 0) && (bus_cyc == ack_at);
    bus_error = bus_ack && ack_err;
    bus_rdata = rdata_val;
  end

  // Monitor: a writeback entry is new when the register was enabled at the previous edge
  logic en_prev = 1'b0, req_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected bus_req: addr 0x%0h, none expected", bus_address);
        end else begin
          be = bus_q.pop_front();
          check("bus_we", bus_we, be.we);
          check("bus_address", bus_address, be.addr);
          check("bus_wdata", bus_wdata, be.wdata);
          check("bus_strobe", bus_strobe, be.strb);
        end
      end
      if (en_prev && valid_out) begin
        if (wb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected valid_out: result 0x%0h, none expected", result_out);
        end else begin
          we_exp = wb_q.pop_front();
          check("exception_out", exception_out, we_exp.exc);
          check("ecause_out", ecause_out, we_exp.ec);
          check("rd_address_out", rd_address_out, we_exp.rd);
          if (we_exp.chk_res) check("result_out", result_out, we_exp.res);
        end
      end
      req_prev = bus_req;
      en_prev  = !stall && !stall_request;
    end
  end

  // Drives one instruction and holds it until the stage accepts it (no stall, no stall_request)
  task automatic run_op(input string name, input logic ld, st, sgn, input logic [1:0] size,
                        input logic [31:0] addr, rs2, alu, input logic [4:0] rd,
                        input logic exc_in, input logic [3:0] ec_in,
                        input int ack, input logic err, input logic [31:0] rdata,
                        input int inv_at, stall_cyc, exp_sr, exp_req);
    int cyc = 0;
    int sr_cnt = 0;
    int req_cnt = 0;
    bit acc = 0;
    @(posedge clk); #1;
    valid_in = 1'b1; load_in = ld; store_in = st; load_signed_in = sgn;
    load_store_size_in = size; alu_addition_in = addr; rs2_data_in = rs2; alu_data_in = alu;
    rd_address_in = rd; exception_in = exc_in; ecause_in = ec_in;
    ack_at = ack; ack_err = err; rdata_val = rdata;
    stall = (stall_cyc > 0); invalidate = 1'b0;
    while (!acc && cyc < 40) begin
      @(negedge clk);
      if (stall_request) sr_cnt++;
      if (bus_req) req_cnt++;
      acc = !stall_request && !stall;
      if (!acc) begin
        @(posedge clk); #1;
        cyc++;
        stall      = (cyc < stall_cyc);
        invalidate = (cyc == inv_at);
      end
    end
    if (!acc) begin
      checks++;
      $display("FAIL %s accept: got none in 40 cycles, expected acceptance", name);
    end
    check({name, " stall_request cycles"}, sr_cnt, exp_sr);
    check({name, " bus_req cycles"}, req_cnt, exp_req);
    if (stall_cyc > 0) check({name, " accept cycle"}, cyc, stall_cyc);
    @(posedge clk); #1;
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0; exception_in = 1'b0; invalidate = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset bus_req", bus_req, 0);
    check("reset valid_out", valid_out, 0);
    check("reset stall_request", stall_request, 0);
    check("reset result_out", result_out, 0);
    check("reset bus_address", bus_address, 0);
    check("reset ecause_out", ecause_out, 0);
    @(posedge clk); #1 reset = 1'b0;

    exp_bus(0, 32'h1000, 32'h0, 4'b1111); exp_wb(0, 0, 5'd1, 32'hDEADBEEF, 1);
    run_op("lw", 1, 0, 0, 2'b10, 32'h1000, 0, 0, 5'd1, 0, 0, 3, 0, 32'hDEADBEEF, -1, 0, 3, 3);
    exp_bus(0, 32'h1000, 32'h0, 4'b1000); exp_wb(0, 0, 5'd2, 32'hFFFFFF80, 1);
    run_op("lb", 1, 0, 1, 2'b00, 32'h1003, 0, 0, 5'd2, 0, 0, 1, 0, 32'h80123456, -1, 0, 1, 1);
    exp_bus(0, 32'h1000, 32'h0, 4'b1000); exp_wb(0, 0, 5'd3, 32'h00000080, 1);
    run_op("lbu", 1, 0, 0, 2'b00, 32'h1003, 0, 0, 5'd3, 0, 0, 1, 0, 32'h80123456, -1, 0, 1, 1);
    exp_bus(0, 32'h1000, 32'h0, 4'b1100); exp_wb(0, 0, 5'd4, 32'hFFFF8001, 1);
    run_op("lh", 1, 0, 1, 2'b01, 32'h1002, 0, 0, 5'd4, 0, 0, 2, 0, 32'h80011234, -1, 0, 2, 2);
    exp_bus(0, 32'h1000, 32'h0, 4'b0011); exp_wb(0, 0, 5'd5, 32'h00001234, 1);
    run_op("lhu", 1, 0, 0, 2'b01, 32'h1000, 0, 0, 5'd5, 0, 0, 1, 0, 32'h80011234, -1, 0, 1, 1);
    exp_bus(1, 32'h2000, 32'hABCD0000, 4'b1100); exp_wb(0, 0, 5'd6, 32'h55, 1);
    run_op("sh", 0, 1, 0, 2'b01, 32'h2002, 32'h0000ABCD, 32'h55, 5'd6, 0, 0, 1, 0, 0, -1, 0, 1, 1);
    exp_bus(1, 32'h2000, 32'h00001200, 4'b0010); exp_wb(0, 0, 5'd7, 32'h66, 1);
    run_op("sb", 0, 1, 0, 2'b00, 32'h2001, 32'h12, 32'h66, 5'd7, 0, 0, 1, 0, 0, -1, 0, 1, 1);
    exp_wb(1, 4'd4, 5'd8, 0, 0);
    run_op("lw misaligned", 1, 0, 0, 2'b10, 32'h1002, 0, 0, 5'd8, 0, 0, 1, 0, 0, -1, 0, 0, 0);
    exp_wb(1, 4'd4, 5'd9, 0, 0);
    run_op("ld on rv32", 1, 0, 0, 2'b11, 32'h1000, 0, 0, 5'd9, 0, 0, 1, 0, 0, -1, 0, 0, 0);
    exp_wb(1, 4'd6, 5'd10, 0, 0);
    run_op("sd on rv32", 0, 1, 0, 2'b11, 32'h1000, 0, 0, 5'd10, 0, 0, 1, 0, 0, -1, 0, 0, 0);
    exp_wb(0, 0, 5'd11, 32'h12345678, 1);
    run_op("alu", 0, 0, 0, 2'b10, 32'h0, 0, 32'h12345678, 5'd11, 0, 0, 1, 0, 0, -1, 0, 0, 0);
    exp_wb(1, 4'd2, 5'd12, 32'hAA, 1);
    run_op("upstream exc", 1, 0, 0, 2'b10, 32'h1000, 0, 32'hAA, 5'd12, 1, 4'd2, 1, 0, 0, -1, 0,
           0, 0);
    exp_bus(0, 32'h3000, 32'h0, 4'b1111); exp_wb(1, 4'd5, 5'd13, 0, 0);
    run_op("timeout", 1, 0, 0, 2'b10, 32'h3000, 0, 0, 5'd13, 0, 0, 0, 0, 0, -1, 0, 4, 4);
    exp_bus(1, 32'h3004, 32'hCAFEF00D, 4'b1111); exp_wb(1, 4'd7, 5'd14, 0, 0);
    run_op("sw error", 0, 1, 0, 2'b10, 32'h3004, 32'hCAFEF00D, 0, 5'd14, 0, 0, 2, 1, 0, -1, 0,
           2, 2);
    exp_bus(1, 32'h2000, 32'h11223344, 4'b1111);
    run_op("sw invalidate", 0, 1, 0, 2'b10, 32'h2000, 32'h11223344, 0, 5'd15, 0, 0, 3, 0, 0, 1,
           0, 3, 3);
    exp_bus(0, 32'h1004, 32'h0, 4'b1111); exp_wb(0, 0, 5'd16, 32'h0BADF00D, 1);
    run_op("lw stall", 1, 0, 0, 2'b10, 32'h1004, 0, 0, 5'd16, 0, 0, 1, 0, 32'h0BADF00D, -1, 4,
           1, 1);

    repeat (4) @(negedge clk);
    check("bus queue drained", bus_q.size(), 0);
    check("writeback queue drained", wb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
